// File: rtl/nmr_bstrm_dpath.sv
// nmr_bstrm_dpath: buffers one decoded command and serialises segments gaplessly onto BSTRM_OUT.
module nmr_bstrm_dpath #(
  parameter int DATA_WIDTH = 120,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DPATH_START,
  output logic                  DPATH_BUF_RDY,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  SEQ_END,
  input  logic                  PATTERN_MODE,
  input  logic                  ALL_1S_MODE,
  input  logic                  ALL_0S_MODE,
  input  logic                  ERR_CLR,
  output logic                  BSTRM_OUT,
  output logic                  BSTRM_ACTIVE,
  output logic                  BSTRM_DONE,
  output logic                  OVF_ERR,
  output logic                  UDR_ERR,
  output logic                  CMD_ERR
);
  localparam int IW = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_STARVE, S_END} state_t;
  state_t state_q, state_d;
  logic hold_valid_q, hold_valid_d, hold_end_q, hold_pat_q, hold_one_q, hold_zero_q;
  logic [DATA_WIDTH-1:0] hold_data_q, sh_q, sh_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] run_q, run_d, run_len;
  logic pat_q, pat_d, out_q, out_d, done_q, done_d, rdy_q, active_q;
  logic ovf_q, udr_q, cmd_q, last, xfer, cap, udr_set, cmd_set, no_mode, multi;
  always_comb begin
    last = pat_q ? (idx_q == '0) : (run_q == CNT_WIDTH'(1));
    xfer = hold_valid_q && (state_q == S_IDLE || state_q == S_STARVE || (state_q == S_SHIFT && last));
    cap = DPATH_START && (!hold_valid_q || xfer);
    hold_valid_d = cap || (hold_valid_q && !xfer);
    run_len = hold_data_q[CNT_WIDTH-1:0];
    no_mode = !(hold_pat_q || hold_one_q || hold_zero_q);
    multi = (hold_pat_q && hold_one_q) || (hold_pat_q && hold_zero_q) || (hold_one_q && hold_zero_q);
    cmd_set = xfer && !hold_end_q && (no_mode || multi || (!hold_pat_q && run_len == '0));
    state_d = state_q;
    out_d = 1'b0;
    pat_d = pat_q;
    sh_d = sh_q;
    idx_d = idx_q;
    run_d = run_q;
    done_d = 1'b0;
    udr_set = 1'b0;
    if (xfer && !hold_end_q) begin
      state_d = S_SHIFT;
      pat_d = hold_pat_q;
      sh_d = hold_data_q >> 1;
      idx_d = IW'(DATA_WIDTH - 1);
      out_d = hold_pat_q ? hold_data_q[0] : hold_one_q;
      // Unflagged or zero-length runs still occupy exactly one cycle
      run_d = (no_mode || run_len == '0) ? CNT_WIDTH'(1) : run_len;
    end else if (xfer) begin
      state_d = (state_q == S_IDLE) ? S_IDLE : S_END;
      done_d = 1'b1;
    end else if (state_q == S_SHIFT) begin
      if (last) begin
        state_d = S_STARVE;
        udr_set = 1'b1;
      end else begin
        out_d = pat_q ? sh_q[0] : out_q;
        sh_d = sh_q >> 1;
        idx_d = pat_q ? idx_q - IW'(1) : idx_q;
        run_d = pat_q ? run_q : run_q - CNT_WIDTH'(1);
      end
    end else if (state_q == S_END) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      hold_valid_q <= 1'b0;
      hold_end_q <= 1'b0;
      hold_pat_q <= 1'b0;
      hold_one_q <= 1'b0;
      hold_zero_q <= 1'b0;
      hold_data_q <= '0;
      sh_q <= '0;
      idx_q <= '0;
      run_q <= '0;
      pat_q <= 1'b0;
      out_q <= 1'b0;
      done_q <= 1'b0;
      rdy_q <= 1'b1;
      active_q <= 1'b0;
      ovf_q <= 1'b0;
      udr_q <= 1'b0;
      cmd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_valid_q <= hold_valid_d;
      if (cap) begin
        hold_data_q <= DATA_IN;
        hold_end_q <= SEQ_END;
        hold_pat_q <= PATTERN_MODE;
        hold_one_q <= ALL_1S_MODE;
        hold_zero_q <= ALL_0S_MODE;
      end
      sh_q <= sh_d;
      idx_q <= idx_d;
      run_q <= run_d;
      pat_q <= pat_d;
      out_q <= out_d;
      done_q <= done_d;
      rdy_q <= !hold_valid_d;
      active_q <= state_d != S_IDLE;
      ovf_q <= (DPATH_START && !cap) || (ovf_q && !ERR_CLR);
      udr_q <= udr_set || (udr_q && !ERR_CLR);
      cmd_q <= cmd_set || (cmd_q && !ERR_CLR);
    end
  end
  assign DPATH_BUF_RDY = rdy_q;
  assign BSTRM_OUT = out_q;
  assign BSTRM_ACTIVE = active_q;
  assign BSTRM_DONE = done_q;
  assign OVF_ERR = ovf_q;
  assign UDR_ERR = udr_q;
  assign CMD_ERR = cmd_q;
endmodule

// File: doc/nmr_bstrm_dpath.md
# nmr_bstrm_dpath

Bitstream datapath stage directly downstream of the NMR bitstream command counter. It accepts one decoded command per `DPATH_START` pulse into a single-entry holding buffer, then serialises it onto `BSTRM_OUT` as an arbitrary pattern, a run of 1s, or a run of 0s. Consecutive segments are emitted gaplessly. The block reports sequence completion, and flags underrun, overflow and malformed commands.

## Interface
- `DATA_WIDTH`, 120, command payload width; pattern length in bits
- `CNT_WIDTH`, 32, run-length counter width; run length is `DATA_IN[CNT_WIDTH-1:0]`
- `CLK` in 1: single clock, all logic on rising edge
- `RST` in 1: reset, synchronous, active-high
- `DPATH_START` in 1: one-cycle command strobe
- `DPATH_BUF_RDY` out 1: holding buffer empty
- `DATA_IN` in DATA_WIDTH: pattern or run length
- `SEQ_END` in 1: end-of-sequence command
- `PATTERN_MODE`, `ALL_1S_MODE`, `ALL_0S_MODE` in 1 each: segment type
- `ERR_CLR` in 1: clears sticky error flags
- `BSTRM_OUT` out 1: registered serial bitstream
- `BSTRM_ACTIVE` out 1: high from first segment load until end-of-sequence
- `BSTRM_DONE` out 1: one-cycle pulse at end-of-sequence
- `OVF_ERR`, `UDR_ERR`, `CMD_ERR` out 1 each: sticky error flags

## Operation
- Reset values: `DPATH_BUF_RDY`=1. All other outputs are 0. Holding buffer and shifter are empty, and the FSM is in IDLE.
- Capture:
  - At an edge where `DPATH_START`=1, the command (data, flags) is latched into the holding buffer, `hold_valid`<=1 and `DPATH_BUF_RDY`<=0.
  - `DPATH_BUF_RDY` equals `~hold_valid` and is a registered flop.
- Overflow:
  - Applies when `DPATH_START`=1 while `hold_valid`=1 and no transfer occurs at that edge.
  - The new command is dropped and `OVF_ERR`<=1.
  - If a transfer occurs at the same edge, the new command is accepted and no error is raised.
- Transfer: hold→shifter occurs at the edge where `hold_valid`=1 and the shifter is empty or on its last bit. At that edge `hold_valid`<=0.
- Decode at transfer, in priority order:
  - `SEQ_END`: mode flags are ignored and no bits are emitted.
  - `PATTERN_MODE`: emit `DATA_IN[0]` first, LSB-first, exactly `DATA_WIDTH` bits.
  - `ALL_1S_MODE` / `ALL_0S_MODE`: emit constant 1 / 0 for N cycles.
    - If N=0, emit 1 cycle and set `CMD_ERR`<=1.
  - If more than one mode flag is set, the highest-priority mode is used and `CMD_ERR`<=1.
  - If no mode flag is set (and no `SEQ_END`), the segment is emitted as 1 cycle of 0 and `CMD_ERR`<=1.
- FSM states:
  - IDLE:
    - On a transfer, go to SHIFT and set `BSTRM_ACTIVE`<=1.
    - A `SEQ_END` transfer in IDLE pulses `BSTRM_DONE` and stays in IDLE.
  - SHIFT:
    - Output one bit per cycle; the down-counter holds the remaining bits.
    - On the last bit:
      - hold holds a normal segment: stay in SHIFT with the new segment.
      - hold holds `SEQ_END`: go to END.
      - hold is empty: go to STARVE.
  - STARVE:
    - `BSTRM_OUT`=0 and `UDR_ERR`<=1 on entry.
    - Go to SHIFT on the next transfer, or to END on a `SEQ_END` transfer.
  - END:
    - Lasts 1 cycle: `BSTRM_OUT`=0, `BSTRM_DONE`=1, `BSTRM_ACTIVE`<=0, then go to IDLE.
- Sticky flags:
  - Cleared by `RST` or `ERR_CLR`.
  - A set condition at the same edge as `ERR_CLR` wins.
- Counter widths:
  - Pattern bit index: ceil(log2(`DATA_WIDTH`)) bits.
  - Run counter: `CNT_WIDTH` bits, down-counting to 1, with no wrap.
- Reset mid-sequence: at the reset edge everything returns to reset values, including any buffered command, and no `BSTRM_DONE` is generated.

## Timing
- Latency, shifter empty: `DPATH_START` sampled at edge e → `DPATH_BUF_RDY`=0 in cycle e+1 → transfer at edge e+1 → first bit on `BSTRM_OUT` in cycle e+2, with `DPATH_BUF_RDY`=1 in the same cycle.
- Gapless chaining: if the last bit of segment A is output in cycle k and `hold_valid`=1, bit 0 of segment B is output in cycle k+1.
- Upstream loop: the upstream FSM waits for `DPATH_BUF_RDY`=1 before issuing the next command. Its command turnaround is 6 cycles, so segments of at least 8 cycles guarantee no underrun.
- `BSTRM_DONE` pulse: the cycle after the final bit of the last segment.

## Test plan
- **Pattern:** reset; `DPATH_START` with `PATTERN_MODE`=1, `DATA_IN`=0x…A5 (DATA_WIDTH=120) → starting 2 cycles later, `BSTRM_OUT` = 1,0,1,0,0,1,0,1, then 112 zeros.
- **Gapless runs:** `ALL_1S_MODE` N=10, then `ALL_0S_MODE` N=12 issued while the first is shifting, then `SEQ_END` → 10 ones, 12 zeros with no gap, `BSTRM_DONE` high 1 cycle after, `BSTRM_ACTIVE` low after; all error flags 0.
- **Underrun:** `ALL_1S_MODE` N=2 with the next command delayed 5 cycles → `BSTRM_OUT`=0 in the gap, `UDR_ERR`=1 sticky; then `ERR_CLR` → `UDR_ERR`=0.
- **Overflow:** two `DPATH_START` pulses 1 cycle apart while a N=50 run is shifting → second command dropped, `OVF_ERR`=1, output continues with the first buffered segment.
- **Malformed commands:** `ALL_0S_MODE` N=0, then `PATTERN_MODE`+`ALL_1S_MODE` together → 1 cycle of 0, then pattern mode used; `CMD_ERR`=1.
- **Reset mid-run:** assert `RST` during the 30th bit of an N=100 run → next cycle all outputs are 0, `DPATH_BUF_RDY`=1, no `BSTRM_DONE`; a subsequent command behaves as after power-up.
